// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC bus-cycle scheduler: state encodings,
// default bus widths and requester index assignments.
package rtc_bus_pkg;

   // Default RTC register address and data widths
   localparam int unsigned AW_DEF   = 8;
   localparam int unsigned DW_DEF   = 8;
   localparam int unsigned NREQ_DEF = 3;

   // Scheduler FSM state encodings (kept as plain constants for legacy users)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Requester slots, index 0 has the highest priority
   localparam int unsigned REQ_INIT = 0;
   localparam int unsigned REQ_USER = 1;
   localparam int unsigned REQ_POLL = 2;

endpackage

// File: rtl/rtc_prio_encoder.sv
// Combinational fixed-priority encoder: the lowest-index set request wins.
// Produces a one-hot grant vector, the binary index and a valid flag.
module rtc_prio_encoder #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   // Scan from the highest index down so the lowest set bit is written last
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[N-1-i]) begin
            onehot         = '0;
            onehot[N-1-i]  = 1'b1;
            idx            = IW'(N-1-i);
            valid          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the single RTC bus-cycle engine between NREQ requesters with
// fixed priority (index 0 highest). One transaction at a time:
// IDLE -> ISSUE (start pulse) -> WAIT (engine busy) -> RESP (done pulse).
// Optional engine watchdog: define RTC_BUS_SCHED_TIMEOUT_EN.
module rtc_bus_scheduler
   import rtc_bus_pkg::*;
#(
   parameter int unsigned NREQ           = NREQ_DEF,
   parameter int unsigned AW             = AW_DEF,
   parameter int unsigned DW             = DW_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      rdata,
   output logic               err,
   output logic               eng_start,
   output logic               eng_write,
   output logic [AW-1:0]      eng_addr,
   output logic [DW-1:0]      eng_wdata,
   input  logic               eng_done,
   input  logic [DW-1:0]      eng_rdata,
   output logic               busy
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] win_q,   win_d;
   logic            write_q, write_d;
   logic [AW-1:0]   addr_q,  addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;

   logic [NREQ-1:0] sel_onehot;
   logic [IW-1:0]   sel_idx;
   logic            sel_valid;
   int unsigned     sel;

`ifdef RTC_BUS_SCHED_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   rtc_prio_encoder #(
      .N  (NREQ),
      .IW (IW)
   ) u_prio (
      .req    (req),
      .onehot (sel_onehot),
      .idx    (sel_idx),
      .valid  (sel_valid)
   );

   // Next-state and datapath capture for the arbitration FSM
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      sel     = int'(sel_idx);
`ifdef RTC_BUS_SCHED_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (sel_valid) begin
               win_d   = sel_onehot;
               write_d = req_we[sel_idx];
               addr_d  = req_addr[sel*AW +: AW];
               wdata_d = req_wdata[sel*DW +: DW];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
`ifdef RTC_BUS_SCHED_TIMEOUT_EN
            cnt_d = '0;
            err_d = 1'b0;
`endif
            if (eng_done) begin
               rdata_d = eng_rdata;
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (eng_done) begin
               rdata_d = eng_rdata;
               state_d = ST_RESP;
            end
`ifdef RTC_BUS_SCHED_TIMEOUT_EN
            // Abort when this WAIT cycle would bring the count to TIMEOUT_CYCLES-1
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef RTC_BUS_SCHED_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef RTC_BUS_SCHED_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // Output decode: grant and done are gated by state so reset clears them
   always_comb begin
      busy      = (state_q != ST_IDLE);
      eng_start = (state_q == ST_ISSUE);
      gnt       = busy ? win_q : '0;
      done      = (state_q == ST_RESP) ? win_q : '0;
      eng_write = write_q;
      eng_addr  = addr_q;
      eng_wdata = wdata_q;
      rdata     = rdata_q;
`ifdef RTC_BUS_SCHED_TIMEOUT_EN
      err       = (state_q == ST_RESP) && err_q;
`else
      err       = 1'b0;
`endif
   end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Directed self-checking bench for rtc_bus_scheduler. Inputs are driven and
// outputs sampled on the falling clock edge. The timeout scenario is only
// exercised when RTC_BUS_SCHED_TIMEOUT_EN is defined.
module tb_rtc_bus_scheduler;

   localparam int unsigned NREQ = 3;
   localparam int unsigned AW   = 8;
   localparam int unsigned DW   = 8;
`ifdef RTC_BUS_SCHED_TIMEOUT_EN
   localparam int unsigned TO_CYC = 16;
`else
   localparam int unsigned TO_CYC = 1024;
`endif

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [DW-1:0]      rdata;
   logic               err;
   logic               eng_start;
   logic               eng_write;
   logic [AW-1:0]      eng_addr;
   logic [DW-1:0]      eng_wdata;
   logic               eng_done;
   logic [DW-1:0]      eng_rdata;
   logic               busy;

   int n_checks  = 0;
   int n_fail    = 0;
   int start_cnt = 0;
   int multi_gnt = 0;

   rtc_bus_scheduler #(
      .NREQ           (NREQ),
      .AW             (AW),
      .DW             (DW),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .eng_start (eng_start),
      .eng_write (eng_write),
      .eng_addr  (eng_addr),
      .eng_wdata (eng_wdata),
      .eng_done  (eng_done),
      .eng_rdata (eng_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Count start pulses and any cycle with more than one grant bit set
   always @(posedge clk) begin
      if (eng_start) start_cnt++;
      if (!$onehot0(gnt)) multi_gnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Bounded wait for the engine start pulse
   task automatic wait_start(input string tag);
      int k;
      k = 0;
      while (eng_start !== 1'b1 && k < 32) begin
         tick();
         k++;
      end
      check({tag, "_start"}, 32'(eng_start), 32'd1);
   endtask

   // Engine model: pulse eng_done after 'delay' cycles, return in the RESP cycle
   task automatic respond(input int delay, input logic [7:0] d);
      repeat (delay) tick();
      eng_done  = 1'b1;
      eng_rdata = d;
      tick();
      eng_done  = 1'b0;
      eng_rdata = '0;
   endtask

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      eng_done  = 1'b0;
      eng_rdata = '0;
      repeat (3) tick();

      check("rst_busy",  32'(busy),      32'd0);
      check("rst_gnt",   32'(gnt),       32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_start", 32'(eng_start), 32'd0);
      check("rst_err",   32'(err),       32'd0);
      check("rst_rdata", 32'(rdata),     32'd0);
      check("rst_addr",  32'(eng_addr),  32'd0);
      reset = 1'b0;
      tick();

      // Single read from requester 2, engine answers 5 cycles after start
      req_addr[2*AW +: AW] = 8'h21;
      req[2] = 1'b1;
      tick();
      check("t1_start", 32'(eng_start), 32'd1);
      check("t1_gnt",   32'(gnt),       32'b100);
      check("t1_addr",  32'(eng_addr),  32'h21);
      check("t1_we",    32'(eng_write), 32'd0);
      repeat (5) tick();
      eng_done  = 1'b1;
      eng_rdata = 8'h59;
      check("t1_done_early", 32'(done), 32'd0);
      tick();
      eng_done  = 1'b0;
      eng_rdata = '0;
      check("t1_done",   32'(done),  32'b100);
      check("t1_rdata",  32'(rdata), 32'h59);
      check("t1_err",    32'(err),   32'd0);
      check("t1_nstart", 32'(start_cnt), 32'd1);
      req = '0;
      tick();
      check("t1_idle_busy", 32'(busy), 32'd0);
      check("t1_idle_gnt",  32'(gnt),  32'd0);
      check("t1_idle_done", 32'(done), 32'd0);

      // Contention: all three request together, served 0, 1, 2
      req_addr = {8'h12, 8'h11, 8'h10};
      req = 3'b111;
      for (int k = 0; k < 3; k++) begin
         wait_start($sformatf("t2_%0d", k));
         check($sformatf("t2_gnt%0d", k),  32'(gnt),      32'd1 << k);
         check($sformatf("t2_addr%0d", k), 32'(eng_addr), 32'h10 + 32'(k));
         respond(1, 8'hA0 + 8'(k));
         check($sformatf("t2_done%0d", k),  32'(done),  32'd1 << k);
         check($sformatf("t2_rdata%0d", k), 32'(rdata), 32'hA0 + 32'(k));
         req[k] = 1'b0;
         tick();
         check($sformatf("t2_gap%0d", k), 32'(busy), 32'd0);
      end
      check("t2_nstart",   32'(start_cnt), 32'd4);
      check("t2_multignt", 32'(multi_gnt), 32'd0);

      // Write passthrough from requester 1
      req_we[1] = 1'b1;
      req_addr[1*AW +: AW]  = 8'h02;
      req_wdata[1*DW +: DW] = 8'h30;
      req[1] = 1'b1;
      wait_start("t3");
      check("t3_we",    32'(eng_write), 32'd1);
      check("t3_wdata", 32'(eng_wdata), 32'h30);
      check("t3_addr",  32'(eng_addr),  32'h02);
      respond(2, 8'h77);
      check("t3_done",  32'(done), 32'b010);
      req       = '0;
      req_we    = '0;
      req_wdata = '0;
      repeat (3) tick();
      check("t3_we_hold",    32'(eng_write), 32'd1);
      check("t3_wdata_hold", 32'(eng_wdata), 32'h30);
      check("t3_busy",       32'(busy),      32'd0);

      // Reset two cycles after start aborts silently
      req_addr[0*AW +: AW] = 8'h05;
      req[0] = 1'b1;
      wait_start("t4");
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("t4_busy",  32'(busy),      32'd0);
      check("t4_gnt",   32'(gnt),       32'd0);
      check("t4_done",  32'(done),      32'd0);
      check("t4_start", 32'(eng_start), 32'd0);
      check("t4_addr",  32'(eng_addr),  32'd0);
      check("t4_we",    32'(eng_write), 32'd0);
      check("t4_rdata", 32'(rdata),     32'd0);
      reset = 1'b0;
      wait_start("t4b");
      check("t4b_addr", 32'(eng_addr), 32'h05);
      respond(1, 8'h3C);
      check("t4b_done",  32'(done),  32'b001);
      check("t4b_rdata", 32'(rdata), 32'h3C);
      req = '0;
      tick();

      // Requester drops req in WAIT; then a spurious eng_done in IDLE
      req_addr[2*AW +: AW] = 8'h40;
      req[2] = 1'b1;
      wait_start("t5");
      tick();
      req = '0;
      respond(2, 8'h99);
      check("t5_done",  32'(done),  32'b100);
      check("t5_rdata", 32'(rdata), 32'h99);
      tick();
      check("t5_idle", 32'(busy), 32'd0);
      eng_done  = 1'b1;
      eng_rdata = 8'hEE;
      tick();
      eng_done  = 1'b0;
      eng_rdata = '0;
      check("t5_sp_busy",  32'(busy),      32'd0);
      check("t5_sp_start", 32'(eng_start), 32'd0);
      check("t5_sp_done",  32'(done),      32'd0);
      check("t5_sp_gnt",   32'(gnt),       32'd0);
      check("t5_sp_rdata", 32'(rdata),     32'h99);

`ifdef RTC_BUS_SCHED_TIMEOUT_EN
      // Engine never answers: watchdog ends the transaction 16 cycles after start
      req_addr[1*AW +: AW] = 8'h33;
      req[1] = 1'b1;
      wait_start("t6");
      repeat (15) tick();
      check("t6_done_early", 32'(done), 32'd0);
      check("t6_err_early",  32'(err),  32'd0);
      tick();
      check("t6_done",  32'(done),  32'b010);
      check("t6_err",   32'(err),   32'd1);
      check("t6_rdata", 32'(rdata), 32'd0);
      check("t6_busy",  32'(busy),  32'd1);
      req       = '0;
      eng_done  = 1'b1;
      eng_rdata = 8'hDD;
      tick();
      eng_done  = 1'b0;
      eng_rdata = '0;
      check("t6_after_busy", 32'(busy), 32'd0);
      check("t6_after_err",  32'(err),  32'd0);
      check("t6_after_done", 32'(done), 32'd0);
      tick();
      check("t6_late_rdata", 32'(rdata), 32'd0);
      check("t6_late_busy",  32'(busy),  32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
